y86_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the sequential Y86-64 core. It steps one instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC_UPDATE, one stage per state, each driven by an explicit stage strobe. It owns the architectural PC and the status register (AOK/HLT/ADR/INS), and supports a variable-latency data-memory handshake with a timeout. It also keeps cycle and retired-instruction counters and replaces the free-running combinational PC/stat loop of the previous core top.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/y86_seq_ctrl_if.sv | 32 +++
 rtl/y86_mem_wait.sv | 33 +++
 rtl/y86_seq_ctrl.sv | 109 ++++++++++
 tb/tb_y86_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 sequential control path: status codes, sequencer
// states and stage-strobe bit positions.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int unsigned STAGE_FETCH     = 0;
  localparam int unsigned STAGE_DECODE    = 1;
  localparam int unsigned STAGE_EXECUTE   = 2;
  localparam int unsigned STAGE_MEMORY    = 3;
  localparam int unsigned STAGE_WRITEBACK = 4;
  localparam int unsigned STAGE_PC_UPDATE = 5;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcUpdate,
    StHalt
  } seq_state_e;

  function automatic logic [5:0] stage_strobe(seq_state_e s);
    logic [5:0] en;
    en = '0;
    case (s)
      StFetch:     en[STAGE_FETCH]     = 1'b1;
      StDecode:    en[STAGE_DECODE]    = 1'b1;
      StExecute:   en[STAGE_EXECUTE]   = 1'b1;
      StMemory:    en[STAGE_MEMORY]    = 1'b1;
      StWriteback: en[STAGE_WRITEBACK] = 1'b1;
      StPcUpdate:  en[STAGE_PC_UPDATE] = 1'b1;
      default:     en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Signal bundle between the sequencer (master) and the fetch/decode/memory datapath (slave).
interface y86_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] reset_pc;
  logic              instr_valid;
  logic              imem_er;
  logic              hlt_er;
  logic              need_mem;
  logic              mem_ready;
  logic              dmem_er;
  logic [ADDR_W-1:0] new_pc;
  logic [ADDR_W-1:0] pc;
  logic [5:0]        stage_en;
  logic              mem_req;
  logic [2:0]        stat;
  logic              halted;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
    input  start, reset_pc, instr_valid, imem_er, hlt_er, need_mem, mem_ready, dmem_er, new_pc,
    output pc, stage_en, mem_req, stat, halted, cycle_cnt, instr_cnt
  );

  modport slave (
    output start, reset_pc, instr_valid, imem_er, hlt_er, need_mem, mem_ready, dmem_er, new_pc,
    input  pc, stage_en, mem_req, stat, halted, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/y86_mem_wait.sv
// MEMORY-state wait counter: reports normal completion or an address fault, where a
// missing mem_ready after MEM_TIMEOUT cycles counts as a fault.
module y86_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic mem_ready_i,
  input  logic dmem_er_i,
  output logic done_o,
  output logic fault_o
);
  // The cycle whose count would reach MEM_TIMEOUT is the last one allowed.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] wait_q, wait_d;
  logic       timeout;

  assign timeout = active_i && !mem_ready_i && (wait_q == LAST_WAIT);
  assign done_o  = active_i && mem_ready_i && !dmem_er_i;
  assign fault_o = active_i && ((mem_ready_i && dmem_er_i) || timeout);

  always_comb begin
    wait_d = 8'd0;
    if (active_i && !mem_ready_i) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= 8'd0;
    else     wait_q <= wait_d;
  end
endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle Y86-64 sequencer: walks one instruction through the six stages, owns PC and
// status, and counts active cycles and retired instructions.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned IMEM_BYTES  = 2048,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic            clk,
  input logic            rst,
  y86_seq_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_BYTES);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        stat_q, stat_d;
  logic [5:0]        stage_en_q;
  logic              mem_req_q;
  logic              halted_q;
  logic              need_mem_q;
  logic [CNT_W-1:0]  cycle_q, instr_q;
  logic              mem_done, mem_fault;

  y86_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk        (clk),
    .rst        (rst),
    .active_i   (state_q == StMemory),
    .mem_ready_i(bus.mem_ready),
    .dmem_er_i  (bus.dmem_er),
    .done_o     (mem_done),
    .fault_o    (mem_fault)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StFetch;
      StFetch: begin
        if ((pc_q >= IMEM_LIMIT) || bus.imem_er) begin
          stat_d  = STAT_ADR;
          state_d = StHalt;
        end else if (!bus.instr_valid) begin
          stat_d  = STAT_INS;
          state_d = StHalt;
        end else if (bus.hlt_er) begin
          stat_d  = STAT_HLT;
          state_d = StHalt;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = need_mem_q ? StMemory : StWriteback;
      StMemory: begin
        if (mem_fault) begin
          stat_d  = STAT_ADR;
          state_d = StHalt;
        end else if (mem_done) begin
          state_d = StWriteback;
        end
      end
      StWriteback: state_d = StPcUpdate;
      StPcUpdate:  state_d = StFetch;
      StHalt:      state_d = StHalt;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      stat_q     <= STAT_AOK;
      stage_en_q <= '0;
      mem_req_q  <= 1'b0;
      halted_q   <= 1'b0;
      need_mem_q <= 1'b0;
      cycle_q    <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      stage_en_q <= stage_strobe(state_d);
      mem_req_q  <= (state_d == StMemory);
      halted_q   <= (state_d == StHalt);
      if ((state_q != StIdle) && (state_q != StHalt)) cycle_q <= cycle_q + CNT_W'(1);
      if ((state_q == StIdle) && bus.start) pc_q <= bus.reset_pc;
      if (state_q == StDecode) need_mem_q <= bus.need_mem;
      if (state_q == StPcUpdate) begin
        pc_q    <= bus.new_pc;
        instr_q <= instr_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.stage_en  = stage_en_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.stat      = stat_q;
  assign bus.halted    = halted_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;
endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Bench for y86_seq_ctrl: vector table, hand-written corner sequences and a randomized
// instruction stream checked against a per-instruction outcome model.
module tb_y86_seq_ctrl;
  import y86_pkg::*;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned IMEM_BYTES  = 2048;
  localparam int          BUDGET      = 40;

  typedef struct packed {
    logic        valid;
    logic        imem_er;
    logic        hlt_er;
    logic        need_mem;
    logic        dmem_er;
    logic [7:0]  waits;
    logic [63:0] new_pc;
  } instr_t;

  typedef struct packed {
    logic [63:0] rpc;
    instr_t      ins;
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [7:0]  cyc;
    logic [7:0]  mcyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, instr_valid, imem_er, hlt_er, need_mem, mem_ready, dmem_er;
  logic [63:0] reset_pc, new_pc;

  y86_seq_ctrl_if #(.ADDR_W(64), .CNT_W(32)) bus ();

  assign bus.start       = start;
  assign bus.reset_pc    = reset_pc;
  assign bus.instr_valid = instr_valid;
  assign bus.imem_er     = imem_er;
  assign bus.hlt_er      = hlt_er;
  assign bus.need_mem    = need_mem;
  assign bus.mem_ready   = mem_ready;
  assign bus.dmem_er     = dmem_er;
  assign bus.new_pc      = new_pc;

  wire [63:0] pc        = bus.pc;
  wire [5:0]  stage_en  = bus.stage_en;
  wire        mem_req   = bus.mem_req;
  wire [2:0]  stat      = bus.stat;
  wire        halted    = bus.halted;
  wire [31:0] cycle_cnt = bus.cycle_cnt;
  wire [31:0] instr_cnt = bus.instr_cnt;

  y86_seq_ctrl #(
    .ADDR_W     (64),
    .IMEM_BYTES (IMEM_BYTES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  logic [31:0] m_instr, m_cycle;
  logic        m_halted;

  vec_t       vecs[10];
  logic [5:0] walk[5];

  always @(negedge clk) begin
    if (!rst) begin
      assert ($onehot0(stage_en)) else $error("FAIL onehot: stage_en=%b", stage_en);
      assert (!(halted && (stage_en != 6'd0)))
        else $error("FAIL halt_strobe: stage_en=%b", stage_en);
      assert (mem_req == stage_en[STAGE_MEMORY])
        else $error("FAIL mem_req_strobe: mem_req=%b stage_en=%b", mem_req, stage_en);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    start = 1'b0; reset_pc = '0; instr_valid = 1'b1; imem_er = 1'b0; hlt_er = 1'b0;
    need_mem = 1'b0; mem_ready = 1'b0; dmem_er = 1'b0; new_pc = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [63:0] rpc);
    start    = 1'b1;
    reset_pc = rpc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Run one instruction from FETCH; memory answers on MEMORY cycle waits+1.
  task automatic exec_instr(input instr_t t, output int cyc, output int mcyc);
    cyc = 0; mcyc = 0;
    instr_valid = t.valid; imem_er = t.imem_er; hlt_er = t.hlt_er;
    need_mem = t.need_mem; dmem_er = t.dmem_er; new_pc = t.new_pc; mem_ready = 1'b0;
    do begin
      if (mem_req) begin
        mcyc++;
        mem_ready = (mcyc == int'(t.waits) + 1);
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end while (!((stage_en == 6'h01) || halted) && (cyc < BUDGET));
    mem_ready = 1'b0;
    if (cyc >= BUDGET) begin
      n_total++;
      $display("FAIL budget: instruction still running after %0d cycles, limit %0d", cyc, BUDGET);
    end
  endtask

  task automatic predict(input instr_t t, output int ecyc, output int emcyc);
    emcyc = 0;
    if ((m_pc >= 64'(IMEM_BYTES)) || t.imem_er) begin
      m_stat = STAT_ADR; ecyc = 1;
    end else if (!t.valid) begin
      m_stat = STAT_INS; ecyc = 1;
    end else if (t.hlt_er) begin
      m_stat = STAT_HLT; ecyc = 1;
    end else if (!t.need_mem) begin
      ecyc = 5; m_pc = t.new_pc; m_instr++;
    end else if (int'(t.waits) >= int'(MEM_TIMEOUT)) begin
      emcyc = MEM_TIMEOUT; ecyc = 3 + emcyc; m_stat = STAT_ADR;
    end else if (t.dmem_er) begin
      emcyc = int'(t.waits) + 1; ecyc = 3 + emcyc; m_stat = STAT_ADR;
    end else begin
      emcyc = int'(t.waits) + 1; ecyc = 5 + emcyc; m_pc = t.new_pc; m_instr++;
    end
    m_halted = (m_stat != STAT_AOK);
    m_cycle  = m_cycle + 32'(ecyc);
  endtask

  function automatic vec_t mkv(input logic [63:0] rpc, input logic v, input logic ie,
                               input logic he, input logic nm, input logic de,
                               input logic [7:0] w, input logic [63:0] npc,
                               input logic [2:0] st, input logic [63:0] epc,
                               input logic [7:0] c, input logic [7:0] mc);
    vec_t r;
    r.rpc = rpc;
    r.ins = '{valid: v, imem_er: ie, hlt_er: he, need_mem: nm, dmem_er: de, waits: w,
              new_pc: npc};
    r.stat = st; r.pc = epc; r.cyc = c; r.mcyc = mc;
    return r;
  endfunction

  initial begin
    instr_t      t;
    logic [63:0] rpc;
    int          cyc, mcyc, ecyc, emcyc;

    walk[0] = 6'h01; walk[1] = 6'h02; walk[2] = 6'h04; walk[3] = 6'h10; walk[4] = 6'h20;

    //                rpc      v  ie he nm de w   new_pc   stat      pc       cyc mcyc
    vecs[0] = mkv(64'h010, 1, 0, 0, 0, 0, 0, 64'h012, STAT_AOK, 64'h012, 5, 0);
    vecs[1] = mkv(64'h020, 1, 0, 0, 1, 0, 2, 64'h02a, STAT_AOK, 64'h02a, 8, 3);
    vecs[2] = mkv(64'h030, 1, 0, 0, 1, 0, 9, 64'h034, STAT_ADR, 64'h030, 7, 4);
    vecs[3] = mkv(64'h040, 0, 0, 0, 0, 0, 0, 64'h044, STAT_INS, 64'h040, 1, 0);
    vecs[4] = mkv(64'h050, 1, 0, 1, 0, 0, 0, 64'h051, STAT_HLT, 64'h050, 1, 0);
    vecs[5] = mkv(64'h060, 0, 1, 0, 0, 0, 0, 64'h061, STAT_ADR, 64'h060, 1, 0);
    vecs[6] = mkv(64'h070, 1, 0, 0, 1, 1, 1, 64'h07a, STAT_ADR, 64'h070, 5, 2);
    vecs[7] = mkv(64'h800, 1, 0, 0, 0, 0, 0, 64'h802, STAT_ADR, 64'h800, 1, 0);
    vecs[8] = mkv(64'h7ff, 1, 0, 0, 0, 0, 0, 64'h801, STAT_AOK, 64'h801, 5, 0);
    vecs[9] = mkv(64'h090, 1, 0, 0, 1, 0, 3, 64'h09a, STAT_AOK, 64'h09a, 9, 4);

    // Reset values.
    do_reset();
    chk("rst_pc", pc, 64'h0);
    chk("rst_stat", {61'd0, stat}, {61'd0, STAT_AOK});
    chk("rst_stage_en", {58'd0, stage_en}, 64'h0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'h0);
    chk("rst_halted", {63'd0, halted}, 64'h0);
    chk("rst_cycle_cnt", {32'd0, cycle_cnt}, 64'h0);
    chk("rst_instr_cnt", {32'd0, instr_cnt}, 64'h0);

    // Stage strobe walk for a non-memory instruction.
    do_start(64'h10);
    instr_valid = 1'b1; need_mem = 1'b0; new_pc = 64'h12;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("walk%0d_stage_en", i), {58'd0, stage_en}, {58'd0, walk[i]});
      @(negedge clk);
    end
    chk("walk_pc", pc, 64'h12);
    chk("walk_instr_cnt", {32'd0, instr_cnt}, 64'd1);
    chk("walk_cycle_cnt", {32'd0, cycle_cnt}, 64'd5);
    chk("walk_stat", {61'd0, stat}, {61'd0, STAT_AOK});

    for (int i = 0; i < 10; i++) begin
      do_reset();
      do_start(vecs[i].rpc);
      exec_instr(vecs[i].ins, cyc, mcyc);
      chk($sformatf("vec%0d_stat", i), {61'd0, stat}, {61'd0, vecs[i].stat});
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_cycles", i), 64'(cyc), {56'd0, vecs[i].cyc});
      chk($sformatf("vec%0d_mem_cycles", i), 64'(mcyc), {56'd0, vecs[i].mcyc});
      chk($sformatf("vec%0d_instr_cnt", i), {32'd0, instr_cnt},
          (vecs[i].stat == STAT_AOK) ? 64'd1 : 64'd0);
      chk($sformatf("vec%0d_halted", i), {63'd0, halted},
          (vecs[i].stat == STAT_AOK) ? 64'd0 : 64'd1);
    end

    // Out-of-range new_pc faults at the following FETCH.
    do_reset();
    do_start(64'h100);
    t = '{valid: 1'b1, imem_er: 1'b0, hlt_er: 1'b0, need_mem: 1'b0, dmem_er: 1'b0,
          waits: 8'd0, new_pc: 64'h800};
    exec_instr(t, cyc, mcyc);
    chk("oor_first_stat", {61'd0, stat}, {61'd0, STAT_AOK});
    exec_instr(t, cyc, mcyc);
    chk("oor_stat", {61'd0, stat}, {61'd0, STAT_ADR});
    chk("oor_pc", pc, 64'h800);
    chk("oor_instr_cnt", {32'd0, instr_cnt}, 64'd1);
    chk("oor_cycle_cnt", {32'd0, cycle_cnt}, 64'd6);

    // Asynchronous reset while MEMORY is waiting.
    do_reset();
    do_start(64'h50);
    t.new_pc = 64'h60;
    exec_instr(t, cyc, mcyc);
    need_mem = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    chk("midmem_in_memory", {63'd0, mem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midmem_pc", pc, 64'h0);
    chk("midmem_stat", {61'd0, stat}, {61'd0, STAT_AOK});
    chk("midmem_stage_en", {58'd0, stage_en}, 64'h0);
    chk("midmem_mem_req", {63'd0, mem_req}, 64'h0);
    chk("midmem_instr_cnt", {32'd0, instr_cnt}, 64'h0);
    chk("midmem_cycle_cnt", {32'd0, cycle_cnt}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midmem_stays_idle", {58'd0, stage_en}, 64'h0);

    // HALT is sticky against start and memory activity.
    do_reset();
    do_start(64'h70);
    t = '{valid: 1'b1, imem_er: 1'b0, hlt_er: 1'b1, need_mem: 1'b0, dmem_er: 1'b0,
          waits: 8'd0, new_pc: 64'h72};
    exec_instr(t, cyc, mcyc);
    reset_pc = 64'h300; new_pc = 64'h400;
    for (int i = 0; i < 6; i++) begin
      start = (i == 1);
      mem_ready = i[0];
      @(negedge clk);
    end
    start = 1'b0; mem_ready = 1'b0;
    chk("halt_stat", {61'd0, stat}, {61'd0, STAT_HLT});
    chk("halt_pc", pc, 64'h70);
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_stage_en", {58'd0, stage_en}, 64'h0);
    chk("halt_cycle_cnt", {32'd0, cycle_cnt}, 64'd1);
    chk("halt_instr_cnt", {32'd0, instr_cnt}, 64'd0);

    // Randomized instruction stream against the outcome model.
    m_halted = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (m_halted) begin
        rpc = ($urandom_range(0, 15) == 0) ? 64'h800 + 64'($urandom_range(0, 255))
                                           : 64'($urandom_range(0, 2047));
        do_reset();
        do_start(rpc);
        m_pc = rpc; m_stat = STAT_AOK; m_instr = '0; m_cycle = '0; m_halted = 1'b0;
      end
      t.valid    = ($urandom_range(0, 11) != 0);
      t.imem_er  = ($urandom_range(0, 15) == 0);
      t.hlt_er   = ($urandom_range(0, 11) == 0);
      t.need_mem = $urandom_range(0, 1) == 1;
      t.dmem_er  = ($urandom_range(0, 7) == 0);
      t.waits    = 8'($urandom_range(0, 5));
      t.new_pc   = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                               : 64'($urandom_range(0, 2047));
      predict(t, ecyc, emcyc);
      exec_instr(t, cyc, mcyc);
      chk($sformatf("rnd%0d_stat", i), {61'd0, stat}, {61'd0, m_stat});
      chk($sformatf("rnd%0d_pc", i), pc, m_pc);
      chk($sformatf("rnd%0d_instr_cnt", i), {32'd0, instr_cnt}, {32'd0, m_instr});
      chk($sformatf("rnd%0d_cycle_cnt", i), {32'd0, cycle_cnt}, {32'd0, m_cycle});
      chk($sformatf("rnd%0d_halted", i), {63'd0, halted}, {63'd0, m_halted});
      chk($sformatf("rnd%0d_cycles", i), 64'(cyc), 64'(ecyc));
      chk($sformatf("rnd%0d_mem_cycles", i), 64'(mcyc), 64'(emcyc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
